// File: rtl/shared_memory_mp_if.sv
// Request/response bundle between NUM_PORTS cache controllers and the shared line memory.
// Per-port fields are packed side by side, port p at slice p of each vector.
interface shared_memory_mp_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = 64,
  parameter int DATA_WIDTH = LINE_BYTES * 8
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*LINE_BYTES-1:0] req_be;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/shared_memory_mp.sv
// Shared line-wide memory behind a round-robin arbiter; byte-enable writes, fixed-latency
// pipelined reads whose responses return on the issuing port in grant order.
module shared_memory_mp #(
  parameter int NUM_PORTS    = 4,
  parameter int MEM_BYTES    = 8 * 1024 * 1024,
  parameter int LINE_BYTES   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = LINE_BYTES * 8,
  parameter int READ_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  shared_memory_mp_if.slave bus
);

  localparam int LAT         = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int NUM_LINES   = MEM_BYTES / LINE_BYTES;
  localparam int INDEX_BITS  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  function automatic logic [PORT_W-1:0] rr_index(input logic [PORT_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return PORT_W'(sum);
  endfunction

  // ---------------- arbiter ----------------
  logic [PORT_W-1:0]    ptr_reg;
  logic [PORT_W-1:0]    ptr_next;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 any_grant;

  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any_grant && bus.req_valid[rr_index(ptr_reg, i)]) begin
        grant[rr_index(ptr_reg, i)] = 1'b1;
        gnt_idx                     = rr_index(ptr_reg, i);
        any_grant                   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (any_grant) begin
      ptr_next = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  assign bus.req_ready = grant;

  // ---------------- accepted request ----------------
  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [LINE_BYTES-1:0] acc_be;
  logic [INDEX_BITS-1:0] line_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  addr_unused;

  assign acc_write = bus.req_write[gnt_idx];
  assign acc_addr  = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign acc_wdata = bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign acc_be    = bus.req_be[int'(gnt_idx)*LINE_BYTES +: LINE_BYTES];
  // Offset and above-capacity bits are dropped so addresses alias modulo MEM_BYTES.
  assign line_idx    = acc_addr[OFFSET_BITS +: INDEX_BITS];
  assign addr_unused = ^acc_addr;
  assign wr_en       = any_grant & acc_write;
  assign rd_en       = any_grant & ~acc_write;

  // ---------------- storage: one RAM per byte lane ----------------
  logic [DATA_WIDTH-1:0] rd_line;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
      logic [7:0] mem_lane [NUM_LINES];
      logic [7:0] rd_byte_reg;

      // Only one grant per cycle, so a read never collides with a write; it sees pre-edge data.
      always_ff @(posedge clk) begin
        if (wr_en && acc_be[gi]) mem_lane[line_idx] <= acc_wdata[gi*8 +: 8];
        if (rd_en)               rd_byte_reg        <= mem_lane[line_idx];
      end

      assign rd_line[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  // ---------------- read pipeline: {valid, port} with reset, line data without ----------------
  logic [LAT-1:0]             st_valid_reg;
  logic [LAT-1:0][PORT_W-1:0] st_port_reg;
  logic [DATA_WIDTH-1:0]      last_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_reg <= '0;
      st_port_reg  <= '0;
    end else begin
      st_valid_reg[0] <= rd_en;
      st_port_reg[0]  <= gnt_idx;
      for (int s = 1; s < LAT; s++) begin
        st_valid_reg[s] <= st_valid_reg[s-1];
        st_port_reg[s]  <= st_port_reg[s-1];
      end
    end
  end

  generate
    if (LAT == 1) begin : g_no_shift
      assign last_line = rd_line;
    end else begin : g_shift
      logic [DATA_WIDTH-1:0] sh_line_reg [LAT-1];

      always_ff @(posedge clk) begin
        sh_line_reg[0] <= rd_line;
        for (int s = 1; s < LAT - 1; s++) sh_line_reg[s] <= sh_line_reg[s-1];
      end

      assign last_line = sh_line_reg[LAT-2];
    end
  endgenerate

  // ---------------- per-port response outputs ----------------
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic                  hit;
      logic [DATA_WIDTH-1:0] held_reg;

      assign hit = st_valid_reg[LAT-1] && (st_port_reg[LAT-1] == PORT_W'(gi));

      // Idle ports keep presenting the last line they were handed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   held_reg <= '0;
        else if (hit) held_reg <= last_line;
      end

      assign bus.resp_valid[gi]                         = hit;
      assign bus.resp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = hit ? last_line : held_reg;
    end
  endgenerate

endmodule

// File: tb/tb_shared_memory_mp.sv
// Directed bench for shared_memory_mp: reset, latency, byte enables, round-robin,
// read/write ordering, address wrap and reset with reads in flight.
module tb_shared_memory_mp;

  localparam int NP   = 4;
  localparam int MEMB = 16384;
  localparam int LB   = 64;
  localparam int AW   = 64;
  localparam int DW   = LB * 8;
  localparam int RL   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shared_memory_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_BYTES(LB), .DATA_WIDTH(DW)) bus ();

  shared_memory_mp #(
    .NUM_PORTS(NP), .MEM_BYTES(MEMB), .LINE_BYTES(LB),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {LB{b}};
  endfunction

  function automatic logic [DW-1:0] onehot(input int p);
    logic [DW-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LB-1:0] be);
    bus.req_valid[p]             = 1'b1;
    bus.req_write[p]             = w;
    bus.req_addr[p*AW +: AW]     = a;
    bus.req_wdata[p*DW +: DW]    = d;
    bus.req_be[p*LB +: LB]       = be;
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [LB-1:0] be);
    @(negedge clk);
    clear_req();
    set_req(p, 1'b1, a, d, be);
    #1;
    check_val("wr_ready", DW'(bus.req_ready), onehot(p));
    $display("write port %0d addr %0h be %0h byte0 %0h", p, a, be, d[7:0]);
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, output logic [DW-1:0] data);
    data = '0;
    @(negedge clk);
    clear_req();
    set_req(p, 1'b0, a, '0, '0);
    #1;
    check_val("rd_ready", DW'(bus.req_ready), onehot(p));
    for (int k = 1; k <= RL; k++) begin
      @(negedge clk);
      clear_req();
      if (k < RL) begin
        check_val("rd_wait", DW'(bus.resp_valid), '0);
      end else begin
        check_val("rd_valid", DW'(bus.resp_valid), onehot(p));
        data = bus.resp_rdata[p*DW +: DW];
      end
    end
    $display("read  port %0d addr %0h byte0 %0h", p, a, data[7:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] rnd;
    logic [NP-1:0] exp_rdy;

    clear_req();

    // 1: reset with random inputs
    rst_n = 1'b0;
    for (int it = 0; it < 3; it++) begin
      @(negedge clk);
      for (int w = 0; w < NP * DW / 32; w++) rnd[(w % (DW / 32)) * 32 +: 32] = $urandom;
      bus.req_valid = NP'($urandom);
      bus.req_write = NP'($urandom);
      bus.req_addr  = {NP*AW/32{$urandom}};
      bus.req_wdata = {NP{rnd}};
      bus.req_be    = {NP*LB/32{$urandom}};
      #1;
      exp_rdy = '0;
      for (int p = NP - 1; p >= 0; p--) if (bus.req_valid[p]) exp_rdy = NP'(1) << p;
      check_val("rst_ready", DW'(bus.req_ready), DW'(exp_rdy));
      check_val("rst_resp_valid", DW'(bus.resp_valid), '0);
      for (int p = 0; p < NP; p++) check_val("rst_resp_rdata", bus.resp_rdata[p*DW +: DW], '0);
      $display("reset cycle %0d valid %b", it, bus.req_valid);
    end
    @(negedge clk);
    clear_req();
    rst_n = 1'b1;

    @(negedge clk);
    set_req(0, 1'b1, 64'h0, '0, '0);
    set_req(2, 1'b1, 64'h0, '0, '0);
    #1;
    check_val("first_grant", DW'(bus.req_ready), DW'(4'b0001));
    @(negedge clk);
    #1;
    check_val("second_grant", DW'(bus.req_ready), DW'(4'b0100));

    // 2: latency
    do_write(1, 64'h40, fill(8'hA5), '1);
    do_read(1, 64'h40, d);
    check_val("lat_data", d, fill(8'hA5));
    @(negedge clk);
    check_val("lat_after_valid", DW'(bus.resp_valid), '0);
    check_val("lat_hold_rdata", bus.resp_rdata[1*DW +: DW], fill(8'hA5));

    // 3: byte enables
    do_write(0, 64'h100, fill(8'h11), '1);
    do_write(0, 64'h100, fill(8'h22), 64'h0F);
    do_read(0, 64'h105, d);
    check_val("be_partial", d, {{60{8'h11}}, {4{8'h22}}});
    do_write(0, 64'h100, fill(8'h33), '0);
    do_read(0, 64'h100, d);
    check_val("be_zero", d, {{60{8'h11}}, {4{8'h22}}});

    // 4: round-robin with all ports holding reads
    for (int p = 0; p < NP; p++) do_write(p, 64'h1000 + 64'(p * 64), fill(8'(8'h40 + p)), '1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      clear_req();
      if (j < 8) for (int p = 0; p < NP; p++) set_req(p, 1'b0, 64'h1000 + 64'(p * 64), '0, '0);
      #1;
      if (j < 8) check_val("rr_grant", DW'(bus.req_ready), onehot(j % 4));
      if (j >= 4) begin
        check_val("rr_resp_valid", DW'(bus.resp_valid), onehot((j - 4) % 4));
        check_val("rr_resp_data", bus.resp_rdata[((j - 4) % 4)*DW +: DW], fill(8'(8'h40 + (j - 4) % 4)));
      end else begin
        check_val("rr_resp_idle", DW'(bus.resp_valid), '0);
      end
      $display("rr cycle %0d ready %b resp %b", j, bus.req_ready, bus.resp_valid);
    end

    // 5: ordering and wrap
    do_write(2, 64'h80, fill(8'h5A), '1);
    @(negedge clk);
    clear_req();
    set_req(3, 1'b0, 64'h80, '0, '0);
    #1;
    check_val("ord_rd_ready", DW'(bus.req_ready), DW'(4'b1000));
    @(negedge clk);
    clear_req();
    set_req(0, 1'b1, 64'h80, fill(8'hC3), '1);
    #1;
    check_val("ord_wr_ready", DW'(bus.req_ready), DW'(4'b0001));
    for (int k = 2; k <= RL; k++) begin
      @(negedge clk);
      clear_req();
      if (k < RL) begin
        check_val("ord_wait", DW'(bus.resp_valid), '0);
      end else begin
        check_val("ord_valid", DW'(bus.resp_valid), DW'(4'b1000));
        check_val("ord_old_data", bus.resp_rdata[3*DW +: DW], fill(8'h5A));
      end
    end
    $display("ordering read port 3 returned byte0 %0h", bus.resp_rdata[3*DW +: 8]);
    do_read(1, 64'h80 + 64'(MEMB), d);
    check_val("wrap_data", d, fill(8'hC3));

    // 6: reset with three reads in flight
    @(negedge clk);
    clear_req();
    set_req(0, 1'b0, 64'h40, '0, '0);
    @(negedge clk);
    clear_req();
    set_req(1, 1'b0, 64'h80, '0, '0);
    @(negedge clk);
    clear_req();
    set_req(2, 1'b0, 64'h100, '0, '0);
    @(negedge clk);
    clear_req();
    rst_n = 1'b0;
    #2;
    check_val("midrst_valid", DW'(bus.resp_valid), '0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("midrst_no_resp", DW'(bus.resp_valid), '0);
    end
    @(negedge clk);
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 64'h0, '0, '0);
    #1;
    check_val("midrst_ptr", DW'(bus.req_ready), DW'(4'b0001));
    $display("mid-flight reset done, grant %b", bus.req_ready);
    @(negedge clk);
    clear_req();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
